// File: rtl/pipe_ex_mdu_ctrl.sv
// Iterative MIPS multiply/divide sequencer for the EX stage: one bit per cycle,
// stalls the front of the pipeline while busy and owns the HI/LO registers.
module pipe_ex_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_md_start,
  input  logic [1:0]       in_md_op,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic             in_flush,
  input  logic             in_hilo_wena,
  input  logic             in_hilo_sel,
  input  logic [WIDTH-1:0] in_hilo_wdata,
  output logic             out_stall,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]     opa;
  logic [CW-1:0]        cnt;
  logic                 is_div, res_neg, rem_neg, div_zero;
  logic [WIDTH-1:0]     hi, lo;

  logic                 start_ok, last_iter;
  logic                 neg_rs, neg_rt;
  logic [WIDTH-1:0]     mag_rs, mag_rt;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_s;
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     diff;
  logic                 ge;
  logic [WIDTH-1:0]     rem_n, q_res, r_res, hi_res, lo_res;

  assign start_ok  = in_md_start & ~in_flush;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Operands are latched as magnitudes; signs are re-applied at commit.
  assign neg_rs = ~in_md_op[0] & in_rs_data[WIDTH-1];
  assign neg_rt = ~in_md_op[0] & in_rt_data[WIDTH-1];
  assign mag_rs = neg_rs ? -in_rs_data : in_rs_data;
  assign mag_rt = neg_rt ? -in_rt_data : in_rt_data;

  // acc = {partial product, remaining multiplier} or {remainder, quotient}.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, opa};
  assign ge       = ~diff[WIDTH+1];
  assign rem_n    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign div_next = {rem_n, acc[WIDTH-2:0], ge};
  assign acc_next = is_div ? div_next : mul_next;

  // With a zero divisor the remainder path rebuilds the dividend magnitude,
  // so re-signing it yields the raw dividend; only LO needs forcing.
  assign prod_s = res_neg ? -acc_next : acc_next;
  assign q_res  = acc_next[WIDTH-1:0];
  assign r_res  = acc_next[2*WIDTH-1:WIDTH];
  assign hi_res = is_div ? (rem_neg ? -r_res : r_res) : prod_s[2*WIDTH-1:WIDTH];
  assign lo_res = is_div ? (div_zero ? {WIDTH{1'b1}} : (res_neg ? -q_res : q_res))
                         : prod_s[WIDTH-1:0];

  always_ff @(posedge in_clk) begin
    if (!in_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = BUSY;
      BUSY:    if (in_flush) state_next = IDLE;
               else if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_stall = 1'b0;
    out_busy  = 1'b0;
    out_done  = 1'b0;
    case (state)
      IDLE:    out_stall = start_ok & in_rst;
      BUSY:    begin out_stall = 1'b1; out_busy = 1'b1; end
      DONE:    out_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      acc      <= '0;
      opa      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hilo_wena) begin
            if (in_hilo_sel) hi <= in_hilo_wdata;
            else             lo <= in_hilo_wdata;
          end
          if (start_ok) begin
            is_div   <= in_md_op[1];
            res_neg  <= neg_rs ^ neg_rt;
            rem_neg  <= neg_rs;
            div_zero <= (in_rt_data == '0);
            cnt      <= '0;
            if (in_md_op[1]) begin
              acc <= {{WIDTH{1'b0}}, mag_rs};
              opa <= mag_rt;
            end else begin
              acc <= {{WIDTH{1'b0}}, mag_rt};
              opa <= mag_rs;
            end
          end
        end
        BUSY: begin
          if (!in_flush) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
              hi <= hi_res;
              lo <= lo_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_hi = hi;
  assign out_lo = lo;

endmodule

// File: tb/tb_pipe_ex_mdu_ctrl.sv
// Directed bench for pipe_ex_mdu_ctrl: hand-computed MULT/DIV results, latency,
// flush, HI/LO writes and reset behaviour.
module tb_pipe_ex_mdu_ctrl;

  localparam int W = 32;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic         in_md_start;
  logic [1:0]   in_md_op;
  logic [W-1:0] in_rs_data, in_rt_data;
  logic         in_flush;
  logic         in_hilo_wena, in_hilo_sel;
  logic [W-1:0] in_hilo_wdata;
  logic         out_stall, out_busy, out_done;
  logic [W-1:0] out_hi, out_lo;

  int checks = 0;
  int errors = 0;

  pipe_ex_mdu_ctrl #(.WIDTH(W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_md_start(in_md_start), .in_md_op(in_md_op),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_flush(in_flush),
    .in_hilo_wena(in_hilo_wena), .in_hilo_sel(in_hilo_sel), .in_hilo_wdata(in_hilo_wdata),
    .out_stall(out_stall), .out_busy(out_busy), .out_done(out_done),
    .out_hi(out_hi), .out_lo(out_lo)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one mult/div with start held through DONE, then check result and latency.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cyc;
    int stall_n;
    @(negedge in_clk);
    in_md_start = 1'b1;
    in_md_op    = op;
    in_rs_data  = a;
    in_rt_data  = b;
    #1;
    cyc = 0;
    stall_n = 0;
    while (!out_done && cyc < 200) begin
      if (out_stall) stall_n++;
      @(negedge in_clk);
      #1;
      cyc++;
    end
    check({tag, "_done_lat"}, cyc, W + 1);
    check({tag, "_stall_cyc"}, stall_n, W + 1);
    check({tag, "_stall_done"}, out_stall, 0);
    check({tag, "_hi"}, out_hi, exp_hi);
    check({tag, "_lo"}, out_lo, exp_lo);
    @(negedge in_clk);
    in_md_start = 1'b0;
    #1;
    check({tag, "_idle_busy"}, out_busy, 0);
    @(negedge in_clk);
    #1;
    check({tag, "_no_restart"}, out_busy, 0);
    check({tag, "_no_stall"}, out_stall, 0);
  endtask

  initial begin
    int done_seen;
    in_rst        = 1'b0;
    in_md_start   = 1'b1;
    in_md_op      = 2'b01;
    in_rs_data    = 32'd5;
    in_rt_data    = 32'd3;
    in_flush      = 1'b0;
    in_hilo_wena  = 1'b0;
    in_hilo_sel   = 1'b0;
    in_hilo_wdata = '0;

    // Reset with start held high: everything quiet.
    @(negedge in_clk);
    @(negedge in_clk);
    #1;
    check("rst_stall", out_stall, 0);
    check("rst_hi", out_hi, 0);
    check("rst_lo", out_lo, 0);
    check("rst_busy", out_busy, 0);
    check("rst_done", out_done, 0);
    in_md_start = 1'b0;
    in_rst = 1'b1;
    @(negedge in_clk);
    #1;
    check("post_rst_busy", out_busy, 0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_wrap",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_negd",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("mult_nn",   2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Flush mid-divide: abort, no commit, no done pulse.
    @(negedge in_clk);
    in_md_start = 1'b1;
    in_md_op    = 2'b11;
    in_rs_data  = 32'd9;
    in_rt_data  = 32'd2;
    repeat (10) @(negedge in_clk);
    in_flush = 1'b1;
    #1;
    check("flush_busy_stall", out_stall, 1);
    @(negedge in_clk);
    in_md_start = 1'b0;
    in_flush    = 1'b0;
    #1;
    check("flush_idle_busy", out_busy, 0);
    check("flush_idle_stall", out_stall, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge in_clk);
      #1;
      if (out_done) done_seen = 1;
    end
    check("flush_no_done", done_seen, 0);
    check("flush_hi", out_hi, 32'hFFFF_FFF7);
    check("flush_lo", out_lo, 32'hFFFF_FFFF);

    // MTLO / MTHI in IDLE.
    @(negedge in_clk);
    in_hilo_wena  = 1'b1;
    in_hilo_sel   = 1'b0;
    in_hilo_wdata = 32'h0000_1234;
    @(negedge in_clk);
    #1;
    check("mtlo_lo", out_lo, 32'h0000_1234);
    check("mtlo_hi", out_hi, 32'hFFFF_FFF7);
    in_hilo_sel   = 1'b1;
    in_hilo_wdata = 32'h0000_ABCD;
    @(negedge in_clk);
    #1;
    check("mthi_hi", out_hi, 32'h0000_ABCD);
    check("mthi_lo", out_lo, 32'h0000_1234);
    in_hilo_wena = 1'b0;

    // Flush beats start in IDLE.
    @(negedge in_clk);
    in_md_start = 1'b1;
    in_flush    = 1'b1;
    in_md_op    = 2'b01;
    #1;
    check("flush_prio_stall", out_stall, 0);
    @(negedge in_clk);
    in_md_start = 1'b0;
    in_flush    = 1'b0;
    #1;
    check("flush_prio_busy", out_busy, 0);

    // Reset mid-operation: abort, HI/LO cleared by reset, no commit afterwards.
    @(negedge in_clk);
    in_md_start = 1'b1;
    in_md_op    = 2'b01;
    in_rs_data  = 32'd3;
    in_rt_data  = 32'd5;
    repeat (5) @(negedge in_clk);
    #1;
    check("midrst_busy_before", out_busy, 1);
    in_rst      = 1'b0;
    in_md_start = 1'b0;
    @(negedge in_clk);
    in_rst = 1'b1;
    #1;
    check("midrst_busy", out_busy, 0);
    check("midrst_hi", out_hi, 0);
    check("midrst_lo", out_lo, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge in_clk);
      #1;
      if (out_done) done_seen = 1;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_lo_kept", out_lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
